// File: rtl/input_ctrl_if.sv
// Ingress bus bundle for input_ctrl: beat stream in, block grants, SRAM writes and queue pushes out.
interface input_ctrl_if #(
  parameter int PORTNUM        = 16,
  parameter int BLK_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH      = 10,
  parameter int DATA_WIDTH     = 32
);
  localparam int PW = $clog2(PORTNUM);

  logic                      i_vld;
  logic                      i_sop;
  logic                      i_eop;
  logic [DATA_WIDTH-1:0]     i_data;
  logic                      o_in_rdy;
  logic                      o_blk_req;
  logic [BLK_ADDR_WIDTH-1:0] i_blk_addr;
  logic                      i_blk_addr_vld;
  logic                      o_wr_en;
  logic [BLK_ADDR_WIDTH+3:0] o_wr_addr;
  logic [DATA_WIDTH-1:0]     o_wr_data;
  logic                      o_que_vld;
  logic [PW-1:0]             o_que_port;
  logic [BLK_ADDR_WIDTH-1:0] o_que_blk_addr;
  logic                      o_que_first;
  logic [LEN_WIDTH-1:0]      o_len;
  logic                      o_len_vld;
  logic                      o_err;

  modport slave (
    input  i_vld, i_sop, i_eop, i_data, i_blk_addr, i_blk_addr_vld,
    output o_in_rdy, o_blk_req, o_wr_en, o_wr_addr, o_wr_data,
           o_que_vld, o_que_port, o_que_blk_addr, o_que_first, o_len, o_len_vld, o_err
  );

  modport master (
    output i_vld, i_sop, i_eop, i_data, i_blk_addr, i_blk_addr_vld,
    input  o_in_rdy, o_blk_req, o_wr_en, o_wr_addr, o_wr_data,
           o_que_vld, o_que_port, o_que_blk_addr, o_que_first, o_len, o_len_vld, o_err
  );
endinterface

// File: rtl/input_ctrl.sv
// Packet ingress: requests 64-byte blocks, writes beats into SRAM and pushes each filled block
// to the destination port queue. All outputs come straight from flops.
module input_ctrl #(
  parameter int PORTNUM        = 16,
  parameter int BLK_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH      = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int BLK_WORDS      = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input_ctrl_if.slave  bus
);
  localparam int PW = $clog2(PORTNUM);
  localparam int OW = $clog2(BLK_WORDS);
  localparam int AW = BLK_ADDR_WIDTH;
  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_BLK, S_RECV, S_PUSH} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [PW-1:0]         port_q, port_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  eop_q, eop_d;
  logic                  first_q, first_d;
  logic [AW-1:0]         blk_q, blk_d;
  logic [OW-1:0]         off_q, off_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;

  logic                  in_rdy_q, in_rdy_d;
  logic                  blk_req_q, blk_req_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW+OW-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  que_vld_q, que_vld_d;
  logic [PW-1:0]         que_port_q, que_port_d;
  logic [AW-1:0]         que_blk_q, que_blk_d;
  logic                  que_first_q, que_first_d;
  logic [LEN_WIDTH-1:0]  len_o_q, len_o_d;
  logic                  len_vld_q, len_vld_d;
  logic                  err_q, err_d;

  logic          acc, last_off;
  logic [CW-1:0] exp_words;

  assign acc       = bus.i_vld & in_rdy_q;
  assign last_off  = (off_q == OW'(BLK_WORDS - 1));
  // Header word plus payload, rounded up to whole words: ceil((len+4)/4).
  assign exp_words = ({1'b0, len_q} + CW'(7)) >> 2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (acc && bus.i_sop) state_d = S_REQ;
      S_REQ:      state_d = S_WAIT_BLK;
      S_WAIT_BLK: if (bus.i_blk_addr_vld) state_d = eop_q ? S_PUSH : S_RECV;
      S_RECV:     if (acc && (bus.i_eop || last_off)) state_d = S_PUSH;
      S_PUSH:     state_d = eop_q ? S_IDLE : S_REQ;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_d       = hdr_q;
    port_d      = port_q;
    len_d       = len_q;
    eop_d       = eop_q;
    first_d     = first_q;
    blk_d       = blk_q;
    off_d       = off_q;
    wcnt_d      = wcnt_q;
    in_rdy_d    = (state_d == S_IDLE) || (state_d == S_RECV);
    blk_req_d   = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    que_vld_d   = 1'b0;
    que_port_d  = '0;
    que_blk_d   = '0;
    que_first_d = 1'b0;
    len_o_d     = '0;
    len_vld_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (bus.i_sop) begin
            hdr_d   = bus.i_data;
            port_d  = bus.i_data[PW-1:0];
            len_d   = bus.i_data[16 +: LEN_WIDTH];
            eop_d   = bus.i_eop;
            first_d = 1'b1;
            wcnt_d  = CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REQ: blk_req_d = 1'b1;
      S_WAIT_BLK: begin
        if (bus.i_blk_addr_vld) begin
          blk_d = bus.i_blk_addr;
          off_d = '0;
          // The header is held back until the first block exists, then lands at word 0.
          if (first_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {bus.i_blk_addr, OW'(0)};
            wr_data_d = hdr_q;
            off_d     = OW'(1);
          end
        end
      end
      S_RECV: begin
        if (acc) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {blk_q, off_q};
          wr_data_d = bus.i_data;
          off_d     = off_q + OW'(1);
          if (wcnt_q != '1) wcnt_d = wcnt_q + CW'(1);
          if (bus.i_sop) err_d = 1'b1;
          if (bus.i_eop) eop_d = 1'b1;
        end
      end
      S_PUSH: begin
        que_vld_d   = 1'b1;
        que_port_d  = port_q;
        que_blk_d   = blk_q;
        que_first_d = first_q;
        len_vld_d   = first_q;
        len_o_d     = first_q ? len_q : '0;
        err_d       = eop_q && (wcnt_q != exp_words);
        first_d     = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hdr_q       <= '0;
      port_q      <= '0;
      len_q       <= '0;
      eop_q       <= 1'b0;
      first_q     <= 1'b0;
      blk_q       <= '0;
      off_q       <= '0;
      wcnt_q      <= '0;
      in_rdy_q    <= 1'b0;
      blk_req_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      que_vld_q   <= 1'b0;
      que_port_q  <= '0;
      que_blk_q   <= '0;
      que_first_q <= 1'b0;
      len_o_q     <= '0;
      len_vld_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hdr_q       <= hdr_d;
      port_q      <= port_d;
      len_q       <= len_d;
      eop_q       <= eop_d;
      first_q     <= first_d;
      blk_q       <= blk_d;
      off_q       <= off_d;
      wcnt_q      <= wcnt_d;
      in_rdy_q    <= in_rdy_d;
      blk_req_q   <= blk_req_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      que_vld_q   <= que_vld_d;
      que_port_q  <= que_port_d;
      que_blk_q   <= que_blk_d;
      que_first_q <= que_first_d;
      len_o_q     <= len_o_d;
      len_vld_q   <= len_vld_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_in_rdy       = in_rdy_q;
  assign bus.o_blk_req      = blk_req_q;
  assign bus.o_wr_en        = wr_en_q;
  assign bus.o_wr_addr      = wr_addr_q;
  assign bus.o_wr_data      = wr_data_q;
  assign bus.o_que_vld      = que_vld_q;
  assign bus.o_que_port     = que_port_q;
  assign bus.o_que_blk_addr = que_blk_q;
  assign bus.o_que_first    = que_first_q;
  assign bus.o_len          = len_o_q;
  assign bus.o_len_vld      = len_vld_q;
  assign bus.o_err          = err_q;
endmodule

// File: tb/tb_input_ctrl.sv
// Scoreboard bench for input_ctrl: directed packets push expected writes/pushes, a monitor pops and compares.
module tb_input_ctrl;
  localparam int PORTNUM = 16, AW = 10, LW = 10, DW = 32;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  input_ctrl_if #(.PORTNUM(PORTNUM), .BLK_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) bus();

  input_ctrl #(.PORTNUM(PORTNUM), .BLK_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW), .BLK_WORDS(16))
    dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  typedef struct {
    logic [AW+3:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [3:0]    port;
    logic [AW-1:0] blk;
    logic          first;
    logic          len_vld;
    logic [LW-1:0] len;
    logic          err;
  } push_t;

  wr_t           wr_q[$];
  push_t         push_q[$];
  logic [AW-1:0] gnt_q[$];
  int checks = 0, failures = 0;
  int err_exp = 0, err_seen = 0;
  int blkreq_cnt = 0;
  int gnt_dly = 2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic push_t mkpush(int port, int blk, int first, int len_vld, int len, int err);
    push_t p;
    p.port = port[3:0]; p.blk = blk[AW-1:0]; p.first = first[0];
    p.len_vld = len_vld[0]; p.len = len[LW-1:0]; p.err = err[0];
    return p;
  endfunction

  function automatic logic [DW-1:0] hdr(int port, int len);
    logic [DW-1:0] h;
    h = '0;
    h[3:0]   = port[3:0];
    h[25:16] = len[9:0];
    return h;
  endfunction

  function automatic logic [DW-1:0] beat_data(int tag, int i, logic [DW-1:0] h);
    if (i == 0) return h;
    return 32'hD000_0000 | (32'(tag) << 8) | 32'(i);
  endfunction

  // Monitor: every output event is matched against the scoreboard queues.
  always @(negedge i_clk) begin : mon
    wr_t w;
    push_t p;
    if (bus.o_blk_req) blkreq_cnt++;
    if (bus.o_wr_en) begin
      if (wr_q.size() == 0) chk("unexp_wr", {63'b0, bus.o_wr_en}, 64'd0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", 64'(bus.o_wr_addr), 64'(w.addr));
        chk("wr_data", 64'(bus.o_wr_data), 64'(w.data));
      end
    end else chk("wr_idle_zero", 64'({bus.o_wr_addr, bus.o_wr_data}), 64'd0);
    if (bus.o_que_vld) begin
      if (push_q.size() == 0) chk("unexp_push", {63'b0, bus.o_que_vld}, 64'd0);
      else begin
        p = push_q.pop_front();
        chk("que_port", 64'(bus.o_que_port), 64'(p.port));
        chk("que_blk", 64'(bus.o_que_blk_addr), 64'(p.blk));
        chk("que_first", 64'(bus.o_que_first), 64'(p.first));
        chk("len_vld", 64'(bus.o_len_vld), 64'(p.len_vld));
        chk("len", 64'(bus.o_len), 64'(p.len));
        chk("push_err", 64'(bus.o_err), 64'(p.err));
      end
    end else begin
      chk("que_idle_zero", 64'({bus.o_que_port, bus.o_que_blk_addr, bus.o_que_first, bus.o_len, bus.o_len_vld}), 64'd0);
      if (bus.o_err) begin
        err_seen++;
        if (err_seen > err_exp) chk("unexp_err", {63'b0, bus.o_err}, 64'd0);
      end
    end
  end

  // Block allocator model: answers each request after gnt_dly cycles.
  initial begin
    bus.i_blk_addr_vld = 1'b0;
    bus.i_blk_addr = '0;
    forever begin
      @(negedge i_clk);
      if (bus.o_blk_req) begin
        for (int k = 0; k < gnt_dly; k++) begin
          chk("rdy_low_wait", {63'b0, bus.o_in_rdy}, 64'd0);
          @(negedge i_clk);
        end
        if (gnt_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL gnt_avail actual=no_address required=address");
        end else begin
          bus.i_blk_addr = gnt_q.pop_front();
          bus.i_blk_addr_vld = 1'b1;
          @(negedge i_clk);
          bus.i_blk_addr_vld = 1'b0;
          bus.i_blk_addr = '0;
        end
      end
    end
  end

  task automatic send_beat(input logic sop, input logic eop, input logic [DW-1:0] d);
    int n = 0;
    logic r;
    bus.i_vld = 1'b1; bus.i_sop = sop; bus.i_eop = eop; bus.i_data = d;
    forever begin
      r = bus.o_in_rdy;
      @(negedge i_clk);
      if (r) break;
      n++;
      if (n > 100) begin
        checks++; failures++;
        $display("FAIL beat_accept actual=timeout required=accepted");
        break;
      end
    end
    bus.i_vld = 1'b0; bus.i_sop = 1'b0; bus.i_eop = 1'b0; bus.i_data = '0;
  endtask

  task automatic run_pkt(input int tag, input int port, input int len, input int nbeats, input int nsend,
                         input int sop_at, input int b0, input int b1);
    logic [DW-1:0] h;
    wr_t w;
    h = hdr(port, len);
    gnt_q.push_back(b0[AW-1:0]);
    if (nsend > 16) gnt_q.push_back(b1[AW-1:0]);
    for (int i = 0; i < nsend; i++) begin
      w.addr = {(i < 16) ? b0[AW-1:0] : b1[AW-1:0], 4'(i % 16)};
      w.data = beat_data(tag, i, h);
      wr_q.push_back(w);
    end
    for (int i = 0; i < nsend; i++)
      send_beat(i == 0 || i == sop_at, i == nbeats - 1, beat_data(tag, i, h));
  endtask

  task automatic drain(input string nm, input int base_req, input int exp_req);
    int n = 0;
    while ((wr_q.size() != 0 || push_q.size() != 0 || err_seen < err_exp) && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    repeat (4) @(negedge i_clk);
    chk({nm, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    chk({nm, "_push_left"}, 64'(push_q.size()), 64'd0);
    chk({nm, "_gnt_left"}, 64'(gnt_q.size()), 64'd0);
    chk({nm, "_err_count"}, 64'(err_seen), 64'(err_exp));
    chk({nm, "_blk_req"}, 64'(blkreq_cnt - base_req), 64'(exp_req));
  endtask

  initial begin
    int base;
    bus.i_vld = 1'b0; bus.i_sop = 1'b0; bus.i_eop = 1'b0; bus.i_data = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_in_rdy", {63'b0, bus.o_in_rdy}, 64'd0);
    chk("rst_strobes", 64'({bus.o_blk_req, bus.o_wr_en, bus.o_que_vld, bus.o_len_vld, bus.o_err}), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rdy_after_rst", {63'b0, bus.o_in_rdy}, 64'd1);

    // len=60: exactly one full block
    base = blkreq_cnt;
    push_q.push_back(mkpush(3, 'h005, 1, 1, 60, 0));
    run_pkt(1, 3, 60, 16, 16, -1, 'h005, 0);
    drain("len60", base, 1);

    // len=61: spills one word into a second block
    base = blkreq_cnt;
    push_q.push_back(mkpush(2, 'h010, 1, 1, 61, 0));
    push_q.push_back(mkpush(2, 'h011, 0, 0, 0, 0));
    run_pkt(2, 2, 61, 17, 17, -1, 'h010, 'h011);
    drain("len61", base, 2);

    // header-only packet to port 7
    base = blkreq_cnt;
    push_q.push_back(mkpush(7, 'h020, 1, 1, 0, 0));
    run_pkt(3, 7, 0, 1, 1, -1, 'h020, 0);
    drain("len0", base, 1);

    // slow grant: beats must stall, none lost
    base = blkreq_cnt;
    gnt_dly = 10;
    push_q.push_back(mkpush(5, 'h030, 1, 1, 8, 0));
    run_pkt(4, 5, 8, 3, 3, -1, 'h030, 0);
    drain("slow_gnt", base, 1);
    gnt_dly = 2;

    // short packet: len=8 wants 3 words, only 2 arrive
    base = blkreq_cnt;
    push_q.push_back(mkpush(1, 'h031, 1, 1, 8, 1));
    run_pkt(5, 1, 8, 2, 2, -1, 'h031, 0);
    drain("short", base, 1);

    // stray beat in idle is dropped with an error
    base = blkreq_cnt;
    err_exp++;
    send_beat(1'b0, 1'b0, 32'hBAD0_0001);
    drain("stray", base, 0);

    // sop inside a packet: error pulse, beat still stored
    base = blkreq_cnt;
    err_exp++;
    push_q.push_back(mkpush(9, 'h040, 1, 1, 4, 0));
    run_pkt(6, 9, 4, 2, 2, 1, 'h040, 0);
    drain("sop_mid", base, 1);

    // reset after 5 beats of a len=100 packet
    base = blkreq_cnt;
    run_pkt(7, 4, 100, 26, 5, -1, 'h050, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("midrst_in_rdy", {63'b0, bus.o_in_rdy}, 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("midrst_rdy_after", {63'b0, bus.o_in_rdy}, 64'd1);
    repeat (10) @(negedge i_clk);
    drain("midrst", base, 1);

    // first packet after the abandoned one
    base = blkreq_cnt;
    push_q.push_back(mkpush(10, 'h060, 1, 1, 4, 0));
    run_pkt(8, 10, 4, 2, 2, -1, 'h060, 0);
    drain("post_rst", base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
